// File: rtl/uart_frame_rx_if.sv
// ----------------------------------------------------------------------------
// uart_frame_rx_if
//
// Purpose : bundles the two streaming sides of the packet deframer.
//           - uart_unit receive FIFO side: rx_empty, r_data (input to the
//             deframer), rd_uart (pop strobe from the deframer).
//           - payload stream side: pl_data, pl_valid, pl_last (from the
//             deframer), pl_ready (from downstream).
//
// Modports:
//   master : the deframer (drives rd_uart and the pl_* payload stream)
//   slave  : the environment (drives rx_empty, r_data and pl_ready)
// ----------------------------------------------------------------------------
interface uart_frame_rx_if;
    logic       rx_empty;
    logic [7:0] r_data;
    logic       rd_uart;
    logic [7:0] pl_data;
    logic       pl_valid;
    logic       pl_last;
    logic       pl_ready;

    modport master (
        input  rx_empty, r_data, pl_ready,
        output rd_uart, pl_data, pl_valid, pl_last
    );

    modport slave (
        output rx_empty, r_data, pl_ready,
        input  rd_uart, pl_data, pl_valid, pl_last
    );
endinterface

// File: rtl/uart_frame_rx.sv
// ----------------------------------------------------------------------------
// uart_frame_rx
//
// Purpose : packet deframer sitting behind uart_unit's receive FIFO. Hunts for
//           frames SOF, LEN, LEN payload bytes, CHK; buffers the payload and
//           releases it on a valid/ready stream only if the checksum
//           (LEN + payload + CHK) mod 256 is zero. Length, checksum and
//           inter-byte timeout errors drop the frame.
//
// Ports   :
//   clk        system clock
//   reset_n    synchronous active-low reset
//   bus        uart_frame_rx_if.master (rx_empty/r_data/rd_uart FIFO pop,
//              pl_data/pl_valid/pl_last/pl_ready payload stream)
//   frame_ok   one-cycle pulse, frame validated (coincides with first pl_valid)
//   frame_err  one-cycle pulse, frame dropped
//   err_code   last error cause: 01 length, 10 checksum, 11 timeout
//   good_cnt   saturating count of validated frames (stats build only)
//   err_cnt    saturating count of dropped frames (stats build only)
//
// Build option:
//   UART_FRAME_STATS_EN  defined -> good_cnt/err_cnt counters present;
//                        undefined -> both ports tied to zero.
// ----------------------------------------------------------------------------
module uart_frame_rx #(
    parameter int         MAX_LEN     = 16,
    parameter logic [7:0] SOF         = 8'hA5,
    parameter int         TIMEOUT_CYC = 200000
) (
    input  logic            clk,
    input  logic            reset_n,
    uart_frame_rx_if.master bus,
    output logic            frame_ok,
    output logic            frame_err,
    output logic [1:0]      err_code,
    output logic [15:0]     good_cnt,
    output logic [15:0]     err_cnt
);
    localparam int          IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [23:0] TO_LAST   = 24'(TIMEOUT_CYC - 1);

    localparam logic [2:0] S_HUNT    = 3'd0;
    localparam logic [2:0] S_LEN     = 3'd1;
    localparam logic [2:0] S_PAYLOAD = 3'd2;
    localparam logic [2:0] S_CHK     = 3'd3;
    localparam logic [2:0] S_DRAIN   = 3'd4;

    localparam logic [1:0] E_LEN     = 2'b01;
    localparam logic [1:0] E_CHK     = 2'b10;
    localparam logic [1:0] E_TIMEOUT = 2'b11;

    logic [2:0]  state;
    logic [7:0]  len;      // LEN of the frame in progress / being drained
    logic [7:0]  idx;      // payload write index
    logic [7:0]  rd_idx;   // index of the NEXT byte to present in DRAIN
    logic [7:0]  sum;      // running LEN + payload sum, mod 256
    logic [23:0] to_cnt;   // idle cycles since the last accepted byte
    logic [7:0]  pl_mem [MAX_LEN];
    logic        in_frame;
    logic        accept;

    assign in_frame    = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHK);
    // DRAIN never pops, which backpressures the uart_unit FIFO.
    assign bus.rd_uart = !bus.rx_empty && ((state == S_HUNT) || in_frame);
    assign accept      = bus.rd_uart;

    // NOTE: the payload buffer has no reset; DRAIN only reads entries written
    // by the current frame, so reset values would never be observed.
    always_ff @(posedge clk) begin
        if (accept && (state == S_PAYLOAD)) begin
            pl_mem[idx[IDX_W-1:0]] <= bus.r_data;
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // branch below sees the pre-edge values of state, sum, idx and to_cnt.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= S_HUNT;
            len          <= '0;
            idx          <= '0;
            rd_idx       <= '0;
            sum          <= '0;
            to_cnt       <= '0;
            bus.pl_data  <= '0;
            bus.pl_valid <= 1'b0;
            bus.pl_last  <= 1'b0;
            frame_ok     <= 1'b0;
            frame_err    <= 1'b0;
            err_code     <= '0;
        end else begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;

            // Inside a frame, a cycle without an accepted byte means the FIFO
            // is empty; that is the only case where the timeout can advance.
            if (in_frame && !accept) begin
                if (to_cnt == TO_LAST) begin
                    to_cnt    <= '0;
                    frame_err <= 1'b1;
                    err_code  <= E_TIMEOUT;
                    state     <= S_HUNT;
                end else begin
                    to_cnt <= to_cnt + 24'd1;
                end
            end else begin
                to_cnt <= '0;
            end

            case (state)
                S_HUNT: begin
                    if (accept && (bus.r_data == SOF)) begin
                        sum   <= '0;
                        state <= S_LEN;
                    end
                end

                S_LEN: begin
                    if (accept) begin
                        if ((bus.r_data == 8'd0) || (bus.r_data > MAX_LEN_B)) begin
                            frame_err <= 1'b1;
                            err_code  <= E_LEN;
                            state     <= S_HUNT;
                        end else begin
                            len   <= bus.r_data;
                            sum   <= bus.r_data;
                            idx   <= '0;
                            state <= S_PAYLOAD;
                        end
                    end
                end

                S_PAYLOAD: begin
                    if (accept) begin
                        sum <= sum + bus.r_data;
                        idx <= idx + 8'd1;
                        if (idx == len - 8'd1) begin
                            state <= S_CHK;
                        end
                    end
                end

                S_CHK: begin
                    if (accept) begin
                        if ((sum + bus.r_data) == 8'd0) begin
                            // First payload byte is presented together with frame_ok.
                            frame_ok     <= 1'b1;
                            bus.pl_valid <= 1'b1;
                            bus.pl_data  <= pl_mem[0];
                            bus.pl_last  <= (len == 8'd1);
                            rd_idx       <= 8'd1;
                            state        <= S_DRAIN;
                        end else begin
                            frame_err <= 1'b1;
                            err_code  <= E_CHK;
                            state     <= S_HUNT;
                        end
                    end
                end

                S_DRAIN: begin
                    // pl_valid is high throughout DRAIN, so pl_ready alone
                    // marks a handshake.
                    if (bus.pl_ready) begin
                        if (bus.pl_last) begin
                            bus.pl_valid <= 1'b0;
                            bus.pl_last  <= 1'b0;
                            state        <= S_HUNT;
                        end else begin
                            bus.pl_data <= pl_mem[rd_idx[IDX_W-1:0]];
                            bus.pl_last <= (rd_idx == len - 8'd1);
                            rd_idx      <= rd_idx + 8'd1;
                        end
                    end
                end

                default: state <= S_HUNT;
            endcase
        end
    end

`ifdef UART_FRAME_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            good_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            if (frame_ok && (good_cnt != 16'hFFFF)) begin
                good_cnt <= good_cnt + 16'd1;
            end
            if (frame_err && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end
`else
    assign good_cnt = '0;
    assign err_cnt  = '0;
`endif

endmodule

// File: tb/tb_uart_frame_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_frame_rx
//
// Self-checking bench for uart_frame_rx. A FIFO emulator feeds bytes from a
// queue (optionally with random empty gaps), a monitor logs pulses and payload
// handshakes, and a stream-level reference model parses the same byte stream
// to predict frame outcomes and payload.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_frame_rx;
    localparam int MAX_LEN     = 16;
    localparam int TIMEOUT_CYC = 50;
`ifdef UART_FRAME_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame_ok;
    logic        frame_err;
    logic [1:0]  err_code;
    logic [15:0] good_cnt;
    logic [15:0] err_cnt;

    uart_frame_rx_if bus();

    uart_frame_rx #(
        .MAX_LEN    (MAX_LEN),
        .SOF        (8'hA5),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .frame_ok (frame_ok),
        .frame_err(frame_err),
        .err_code (err_code),
        .good_cnt (good_cnt),
        .err_cnt  (err_cnt)
    );

    initial forever #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // environment controls and logs
    byte_q_t    fifo;
    bit         gap_en     = 1'b0;
    int         ready_mode = 0;     // 0 always ready, 1 random, 2 stall on stall_byte
    logic [7:0] stall_byte = 8'h00;
    int         stall_left = 0;
    int         cyc        = 0;
    bit         pop_pending = 1'b0;
    int         ev_q[$];            // 0 = frame_ok, 1..3 = err_code at frame_err
    byte_q_t    got_pl;
    bit         got_last[$];
    int         hs_cyc[$];
    byte_q_t    stall_log;
    int         rd_viol, drain_busy, ok_cyc, err_cyc, last_acc_cyc;

    // reference model results
    int         exp_ev[$];
    byte_q_t    exp_pl;
    bit         exp_last[$];
    int         exp_good, exp_err;
    logic [1:0] exp_code;

    // FIFO emulator + output monitor; everything happens on the falling edge.
    initial begin
        bus.rx_empty = 1'b1;
        bus.r_data   = 8'h00;
        bus.pl_ready = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            if (pop_pending) begin
                void'(fifo.pop_front());
                last_acc_cyc = cyc;
            end
            if (fifo.size() != 0 && !(gap_en && $urandom_range(0, 3) == 0)) begin
                bus.rx_empty = 1'b0;
                bus.r_data   = fifo[0];
            end else begin
                bus.rx_empty = 1'b1;
                bus.r_data   = 8'($urandom);
            end
            case (ready_mode)
                0: bus.pl_ready = 1'b1;
                1: bus.pl_ready = ($urandom_range(0, 2) != 0);
                default: begin
                    if (bus.pl_valid && bus.pl_data == stall_byte && stall_left > 0) begin
                        bus.pl_ready = 1'b0;
                        stall_left--;
                    end else begin
                        bus.pl_ready = 1'b1;
                    end
                end
            endcase
            #1;
            pop_pending = bus.rd_uart;
            if (frame_ok) begin
                ev_q.push_back(0);
                ok_cyc = cyc;
            end
            if (frame_err) begin
                ev_q.push_back(int'(err_code));
                err_cyc = cyc;
            end
            if (bus.pl_valid && bus.pl_ready) begin
                got_pl.push_back(bus.pl_data);
                got_last.push_back(bus.pl_last);
                hs_cyc.push_back(cyc);
            end
            if (bus.pl_valid && !bus.pl_ready) stall_log.push_back(bus.pl_data);
            if (bus.pl_valid && bus.rd_uart) rd_viol++;
            if (bus.pl_valid && !bus.rx_empty) drain_busy++;
        end
    end

    task automatic clear_logs();
        ev_q.delete(); got_pl.delete(); got_last.delete(); hs_cyc.delete();
        stall_log.delete();
        exp_ev.delete(); exp_pl.delete(); exp_last.delete();
        rd_viol = 0; drain_busy = 0; ok_cyc = -1; err_cyc = -1; last_acc_cyc = -1;
    endtask

    // Stream-level parse of a complete byte stream into expected outcomes.
    task automatic model_stream(input byte_q_t s);
        int i = 0;
        int n = s.size();
        while (i < n) begin
            int l;
            int sum;
            if (s[i] != 8'hA5) begin
                i++;
                continue;
            end
            if (i + 1 >= n) break;
            l = int'(s[i+1]);
            i += 2;
            if (l == 0 || l > MAX_LEN) begin
                exp_ev.push_back(1); exp_err++; exp_code = 2'b01;
                continue;
            end
            if (i + l >= n) break;
            sum = l;
            for (int k = 0; k < l; k++) sum += int'(s[i+k]);
            sum += int'(s[i+l]);
            if ((sum % 256) == 0) begin
                exp_ev.push_back(0); exp_good++;
                for (int k = 0; k < l; k++) begin
                    exp_pl.push_back(s[i+k]);
                    exp_last.push_back(k == l - 1);
                end
            end else begin
                exp_ev.push_back(2); exp_err++; exp_code = 2'b10;
            end
            i += l + 1;
        end
    endtask

    task automatic send(input byte_q_t s);
        model_stream(s);
        foreach (s[k]) fifo.push_back(s[k]);
    endtask

    function automatic logic [15:0] sat16(input int v);
        return (v > 65535) ? 16'hFFFF : 16'(v);
    endfunction

    task automatic wait_idle(input int budget, input string name);
        int idle = 0;
        int n = 0;
        while (idle < 4 && n < budget) begin
            @(negedge clk); #2;
            n++;
            if (fifo.size() == 0 && !bus.pl_valid) idle++;
            else idle = 0;
        end
        tests++;
        if (idle < 4) begin
            fails++;
            $display("FAIL %s_idle: not idle after %0d cycles, required idle within %0d", name, n, budget);
        end
    endtask

    task automatic apply_reset(input int cycles);
        @(negedge clk);
        reset_n = 1'b0;
        repeat (cycles) @(negedge clk);
        reset_n = 1'b1;
        #2;
        exp_good = 0; exp_err = 0; exp_code = 2'b00;
    endtask

    task automatic test_reset();
        clear_logs();
        apply_reset(3);
        tests++; if (frame_ok !== 1'b0)       begin fails++; $display("FAIL rst_frame_ok: got %b want 0", frame_ok); end
        tests++; if (frame_err !== 1'b0)      begin fails++; $display("FAIL rst_frame_err: got %b want 0", frame_err); end
        tests++; if (err_code !== 2'b00)      begin fails++; $display("FAIL rst_err_code: got %b want 00", err_code); end
        tests++; if (bus.pl_valid !== 1'b0)   begin fails++; $display("FAIL rst_pl_valid: got %b want 0", bus.pl_valid); end
        tests++; if (bus.pl_last !== 1'b0)    begin fails++; $display("FAIL rst_pl_last: got %b want 0", bus.pl_last); end
        tests++; if (bus.pl_data !== 8'h00)   begin fails++; $display("FAIL rst_pl_data: got %h want 00", bus.pl_data); end
        tests++; if (bus.rd_uart !== 1'b0)    begin fails++; $display("FAIL rst_rd_uart: got %b want 0", bus.rd_uart); end
        tests++; if (good_cnt !== 16'd0 || err_cnt !== 16'd0)
            begin fails++; $display("FAIL rst_stats: got %0d/%0d want 0/0", good_cnt, err_cnt); end
    endtask

    task automatic test_basic();
        clear_logs();
        gap_en = 1'b0; ready_mode = 0;
        send('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97});
        wait_idle(200, "basic");
        tests++; if (ev_q.size() != 1 || ev_q[0] != 0)
            begin fails++; $display("FAIL basic_events: got %0d events (first %0d) want one frame_ok", ev_q.size(), ev_q.size() ? ev_q[0] : -1); end
        tests++; if (got_pl.size() != 3 || got_pl[0] !== 8'h11 || got_pl[1] !== 8'h22 || got_pl[2] !== 8'h33)
            begin fails++; $display("FAIL basic_payload: got %p want 11 22 33", got_pl); end
        tests++; if (got_last.size() != 3 || got_last[0] || got_last[1] || !got_last[2])
            begin fails++; $display("FAIL basic_last: got %p want 0 0 1", got_last); end
        tests++; if (hs_cyc.size() != 3 || hs_cyc[0] != ok_cyc || hs_cyc[1] != ok_cyc + 1 || hs_cyc[2] != ok_cyc + 2)
            begin fails++; $display("FAIL basic_timing: handshake cycles %p, frame_ok at %0d, want consecutive from frame_ok", hs_cyc, ok_cyc); end
        tests++; if (good_cnt !== (STATS ? sat16(exp_good) : 16'd0))
            begin fails++; $display("FAIL basic_good_cnt: got %0d want %0d", good_cnt, STATS ? exp_good : 0); end
    endtask

    task automatic test_chk_err();
        clear_logs();
        send('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h98, 8'hA5, 8'h01, 8'h42, 8'hBD});
        wait_idle(300, "chk");
        tests++; if (ev_q.size() != 2 || ev_q[0] != 2 || ev_q[1] != 0)
            begin fails++; $display("FAIL chk_events: got %p want err(10) then ok", ev_q); end
        tests++; if (got_pl.size() != 1 || got_pl[0] !== 8'h42 || !got_last[0])
            begin fails++; $display("FAIL chk_payload: got %p want 42 (last)", got_pl); end
        tests++; if (err_code !== 2'b10)
            begin fails++; $display("FAIL chk_err_code: got %b want 10", err_code); end
    endtask

    task automatic test_len_err();
        clear_logs();
        send('{8'h00, 8'hFF, 8'hA5, 8'h00, 8'hA5, 8'h11});
        wait_idle(300, "len");
        tests++; if (ev_q.size() != 2 || ev_q[0] != 1 || ev_q[1] != 1)
            begin fails++; $display("FAIL len_events: got %p want err(01) twice", ev_q); end
        tests++; if (got_pl.size() != 0)
            begin fails++; $display("FAIL len_payload: got %0d bytes want 0", got_pl.size()); end
        tests++; if (err_code !== 2'b01)
            begin fails++; $display("FAIL len_err_code: got %b want 01", err_code); end
        tests++; if (err_cnt !== (STATS ? sat16(exp_err) : 16'd0))
            begin fails++; $display("FAIL len_err_cnt: got %0d want %0d", err_cnt, STATS ? exp_err : 0); end
    endtask

    task automatic test_timeout();
        int n = 0;
        clear_logs();
        gap_en = 1'b0;
        fifo.push_back(8'hA5); fifo.push_back(8'h02); fifo.push_back(8'h10);
        while (ev_q.size() == 0 && n < 200) begin
            @(negedge clk); #2;
            n++;
        end
        exp_err++; exp_code = 2'b11;
        tests++; if (ev_q.size() != 1 || ev_q[0] != 3)
            begin fails++; $display("FAIL to_event: got %p after %0d cycles want one err(11)", ev_q, n); end
        tests++; if (err_cyc - last_acc_cyc != TIMEOUT_CYC)
            begin fails++; $display("FAIL to_latency: got %0d cycles want %0d", err_cyc - last_acc_cyc, TIMEOUT_CYC); end
        tests++; if (err_code !== 2'b11)
            begin fails++; $display("FAIL to_err_code: got %b want 11", err_code); end
        send('{8'hA5, 8'h01, 8'h07, 8'hF8});
        @(negedge clk); #2;
        tests++; if (bus.rd_uart !== 1'b1)
            begin fails++; $display("FAIL to_rd_resume: got %b want 1", bus.rd_uart); end
        wait_idle(200, "to");
        tests++; if (got_pl.size() != 1 || got_pl[0] !== 8'h07 || ev_q.size() != 2 || ev_q[1] != 0)
            begin fails++; $display("FAIL to_next_frame: payload %p events %p want 07 / err then ok", got_pl, ev_q); end
    endtask

    task automatic test_backpressure();
        int bad = 0;
        clear_logs();
        gap_en = 1'b0; ready_mode = 2; stall_byte = 8'hBB; stall_left = 5;
        send('{8'hA5, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hCC, 8'hA5, 8'h01, 8'h55, 8'hAA});
        wait_idle(300, "bp");
        foreach (stall_log[k]) if (stall_log[k] !== 8'hBB) bad++;
        tests++; if (stall_log.size() != 5 || bad != 0)
            begin fails++; $display("FAIL bp_stall_hold: stalled bytes %p want BB x5", stall_log); end
        tests++; if (got_pl.size() != 4 || got_pl[0] !== 8'hAA || got_pl[1] !== 8'hBB || got_pl[2] !== 8'hCC || got_pl[3] !== 8'h55)
            begin fails++; $display("FAIL bp_payload: got %p want AA BB CC 55", got_pl); end
        tests++; if (rd_viol != 0 || drain_busy == 0)
            begin fails++; $display("FAIL bp_rd_in_drain: pops during drain %0d (drain cycles with data %0d) want 0", rd_viol, drain_busy); end
        tests++; if (ev_q.size() != 2 || ev_q[0] != 0 || ev_q[1] != 0)
            begin fails++; $display("FAIL bp_events: got %p want ok ok", ev_q); end
        ready_mode = 0;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        clear_logs();
        gap_en = 1'b0; ready_mode = 0;
        fifo.push_back(8'hA5); fifo.push_back(8'h04); fifo.push_back(8'h01); fifo.push_back(8'h02);
        while ((fifo.size() != 0 || pop_pending) && n < 100) begin
            @(negedge clk); #2;
            n++;
        end
        apply_reset(1);
        tests++; if (frame_ok || frame_err || err_code !== 2'b00 || bus.pl_valid || bus.pl_last || bus.pl_data !== 8'h00)
            begin fails++; $display("FAIL rstmid_outputs: ok %b err %b code %b valid %b last %b data %h want all 0",
                                    frame_ok, frame_err, err_code, bus.pl_valid, bus.pl_last, bus.pl_data); end
        tests++; if (good_cnt !== 16'd0 || err_cnt !== 16'd0)
            begin fails++; $display("FAIL rstmid_stats: got %0d/%0d want 0/0", good_cnt, err_cnt); end
        repeat (TIMEOUT_CYC + 10) @(negedge clk);
        #2;
        tests++; if (ev_q.size() != 0)
            begin fails++; $display("FAIL rstmid_no_pulse: got %p want no events", ev_q); end
        send('{8'hA5, 8'h02, 8'h05, 8'h06, 8'hF3});
        wait_idle(200, "rstmid");
        tests++; if (ev_q.size() != 1 || ev_q[0] != 0 || got_pl.size() != 2 || got_pl[0] !== 8'h05 || got_pl[1] !== 8'h06)
            begin fails++; $display("FAIL rstmid_fresh: events %p payload %p want ok / 05 06", ev_q, got_pl); end
        tests++; if (good_cnt !== (STATS ? 16'd1 : 16'd0))
            begin fails++; $display("FAIL rstmid_good_cnt: got %0d want %0d", good_cnt, STATS ? 1 : 0); end
    endtask

    task automatic test_random();
        byte_q_t s;
        int bad_ev = 0, bad_pl = 0;
        clear_logs();
        gap_en = 1'b1; ready_mode = 1;
        for (int f = 0; f < 40; f++) begin
            int kind;
            int l;
            int sum;
            logic [7:0] b;
            kind = $urandom_range(0, 5);
            if (kind <= 3) begin
                l = $urandom_range(1, MAX_LEN);
                s.push_back(8'hA5); s.push_back(8'(l));
                sum = l;
                for (int k = 0; k < l; k++) begin
                    b = ($urandom_range(0, 7) == 0) ? 8'hA5 : 8'($urandom);
                    sum += int'(b);
                    s.push_back(b);
                end
                b = 8'(256 - (sum % 256));
                if (kind == 3) b = b + 8'($urandom_range(1, 255));
                s.push_back(b);
            end else if (kind == 4) begin
                s.push_back(8'hA5);
                s.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
            end else begin
                for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
                    b = 8'($urandom);
                    if (b == 8'hA5) b = 8'h5A;
                    s.push_back(b);
                end
            end
        end
        send(s);
        wait_idle(30000, "rand");
        foreach (exp_ev[k]) if (k >= ev_q.size() || ev_q[k] != exp_ev[k]) bad_ev++;
        foreach (exp_pl[k]) if (k >= got_pl.size() || got_pl[k] !== exp_pl[k] || got_last[k] != exp_last[k]) bad_pl++;
        tests++; if (ev_q.size() != exp_ev.size() || bad_ev != 0)
            begin fails++; $display("FAIL rand_events: got %0d events (%0d differ) want %0d", ev_q.size(), bad_ev, exp_ev.size()); end
        tests++; if (got_pl.size() != exp_pl.size() || bad_pl != 0)
            begin fails++; $display("FAIL rand_payload: got %0d bytes (%0d differ) want %0d", got_pl.size(), bad_pl, exp_pl.size()); end
        tests++; if (err_code !== exp_code)
            begin fails++; $display("FAIL rand_err_code: got %b want %b", err_code, exp_code); end
        tests++; if (rd_viol != 0)
            begin fails++; $display("FAIL rand_rd_in_drain: got %0d pops during drain want 0", rd_viol); end
        tests++; if (good_cnt !== (STATS ? sat16(exp_good) : 16'd0) || err_cnt !== (STATS ? sat16(exp_err) : 16'd0))
            begin fails++; $display("FAIL rand_stats: got %0d/%0d want %0d/%0d", good_cnt, err_cnt,
                                    STATS ? exp_good : 0, STATS ? exp_err : 0); end
        gap_en = 1'b0; ready_mode = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_chk_err();
        test_len_err();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_frame_rx.md
Name: uart_frame_rx

Overview:
- Packet deframer directly downstream of uart_unit's receive FIFO.
- Pops bytes via rd_uart/rx_empty/r_data and hunts for frames of the form SOF(0xA5), LEN, LEN payload bytes, CHK.
- Validates each frame and buffers its payload. Releases the payload on a valid/ready byte stream only when the checksum passes; flags length, checksum and inter-byte timeout errors.

Parameters:
- MAX_LEN, 16: payload buffer depth in bytes; legal LEN is 1..MAX_LEN.
- SOF, 8'hA5: start-of-frame byte.
- TIMEOUT_CYC, 200000: maximum idle clocks between bytes inside a frame; 24-bit counter.

Ports:
- clk, input, 1: system clock.
- reset_n, input, 1: reset, synchronous, active-low.
- rx_empty, input, 1: uart_unit rx FIFO empty.
- r_data, input, 8: uart_unit rx FIFO head byte (first-word-fall-through).
- rd_uart, output, 1: pop strobe to uart_unit; one byte consumed per cycle high.
- pl_data, output, 8: payload byte.
- pl_valid, output, 1: pl_data valid.
- pl_last, output, 1: final payload byte of frame.
- pl_ready, input, 1: downstream accepts byte.
- frame_ok, output, 1: one-cycle pulse, frame validated.
- frame_err, output, 1: one-cycle pulse, frame dropped.
- err_code, output, 2: last error cause (01 len, 10 chk, 11 timeout); held until the next error.
- good_cnt, output, 16: valid-frame count (optional feature).
- err_cnt, output, 16: dropped-frame count (optional feature).

Behaviour:
- Reset (reset_n low at posedge clk):
  - state=HUNT; all outputs 0; err_code=00; buffer index, sum and timeout counter all 0.
  - Reset mid-frame or mid-drain abandons the frame; no pulses are generated.
- rd_uart is combinational: rd_uart = !rx_empty && state in {HUNT, LEN, PAYLOAD, CHK}. A byte is "accepted" in any cycle where rd_uart=1. rd_uart is never high in DRAIN, which backpressures the FIFO.
- HUNT:
  - Accepted byte == SOF -> LEN, sum cleared.
  - Any other byte is discarded silently (no error).
- LEN:
  - Accepted byte is L. If L==0 or L>MAX_LEN -> frame_err, err_code=01, go to HUNT.
  - Otherwise store L, sum=L, idx=0, go to PAYLOAD.
- PAYLOAD:
  - Accepted byte is written to buf[idx]; sum += byte (mod 256); idx++.
  - After the L-th byte, go to CHK.
  - An SOF value inside the payload is ordinary data.
- CHK:
  - Accepted byte C. If (sum + C) mod 256 == 0 -> frame_ok, rd_idx=0, go to DRAIN.
  - Otherwise -> frame_err, err_code=10, go to HUNT.
- DRAIN:
  - pl_valid=1, pl_data=buf[rd_idx], pl_last=(rd_idx==L-1). All are registered, stable while pl_ready is low.
  - On pl_valid&&pl_ready: rd_idx++. If this was pl_last, go to HUNT next cycle and pl_valid drops.
- Pulse timing:
  - frame_ok/frame_err are registered and high for exactly the one cycle after the deciding byte is accepted (or after the timeout).
  - The first pl_valid coincides with frame_ok.
- Timeout:
  - In LEN/PAYLOAD/CHK the counter increments each cycle with rx_empty=1 and clears on each accepted byte.
  - Reaching TIMEOUT_CYC-1 -> frame_err, err_code=11, go to HUNT; the counter clears.
  - The counter is held at 0 in HUNT and DRAIN.
- A timeout cycle and a byte arrival cannot coincide: a timeout only occurs when rx_empty=1.
- Bytes arriving during DRAIN stay in the uart_unit FIFO; overflow there is the FIFO's concern.
- Back-to-back frames: the next frame's SOF can be accepted in the first cycle after the last payload handshake.

Optional Feature:
- UART_FRAME_STATS_EN defined:
  - good_cnt increments on each frame_ok; err_cnt increments on each frame_err.
  - Both are 16-bit, saturate at 16'hFFFF, and are cleared by reset.
- Not defined: good_cnt and err_cnt are tied to 0 and no counter logic is present. Ports exist in both cases.

Test Plan:
- FIFO bytes A5 03 11 22 33 77, pl_ready=1:
  - 0x03+0x11+0x22+0x33=0x69, so chk 0x97 makes the sum 0; this test uses 0x97 in place of 0x77.
  - Expect frame_ok once, then pl_data 11, 22, 33 on consecutive cycles, pl_last on 33. With stats: good_cnt=1.
- Same frame with chk 0x98 -> frame_err, err_code=10, no pl_valid; next frame A5 01 42 BD -> ok, payload 42.
- Bytes 00 FF A5 00 -> leading 00 FF silently discarded; LEN 00 -> frame_err, err_code=01. A5 11 with MAX_LEN=16 -> err_code=01.
- TIMEOUT_CYC=50: send A5 02 10, then hold rx_empty=1 -> frame_err exactly 50 cycles after 10 is accepted, err_code=11, state HUNT, rd_uart resumes.
- Valid 3-byte frame, pl_ready low for 5 cycles on byte 2:
  - pl_data stays at byte 2, no data loss.
  - rd_uart stays 0 while the FIFO is non-empty during DRAIN.
- Assert reset_n low for one cycle mid-PAYLOAD -> all outputs 0, no pulse. A fresh valid frame afterwards completes normally; stats counters read 0 before it.
